// File: rtl/pipe_pkg.sv
// Shared types and constants for the step-indexed pipeline stages.
package pipe_pkg;
  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] N = 16'd4096;

  localparam logic [2:0] STAGE_RST = 3'd0;
  localparam logic [2:0] STAGE_SIM = 3'd6;
  localparam logic [2:0] STAGE_FIN = 3'd7;

  typedef struct packed {
    logic [WIDTH-1:0] center;
    logic [WIDTH-1:0] dnorm;
  } assign_entry_t;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} col_state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/pipe_stage3_collect_if.sv
// Output stream of the collect stage: one assignment entry per handshake.
interface pipe_stage3_collect_if;
  import pipe_pkg::*;
  logic             valid;
  logic             ready;
  logic             last;
  logic [WIDTH-1:0] center;
  logic [WIDTH-1:0] dnorm;

  modport master (output valid, center, dnorm, last, input ready);
  modport slave  (input valid, center, dnorm, last, output ready);
endinterface

// File: rtl/pipe_stage3_collect_mpush_fifo.sv
// Registered FIFO accepting up to PUSH_W lane-ordered entries and releasing one per cycle.
module mpush_fifo #(
  parameter int  DEPTH  = 16,
  parameter int  PUSH_W = 2,
  parameter type entry_t = logic [31:0],
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int PW = $clog2(PUSH_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PW-1:0]             push_cnt,
  input  entry_t [PUSH_W-1:0]       push_data,
  input  logic                      pop,
  output entry_t                    head,
  output logic [CW-1:0]             count,
  output logic [CW-1:0]             free
);
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Caller guarantees push_cnt <= free + pop; a push into a full FIFO lands on
  // the slot being popped this cycle.
  always_ff @(posedge clk)
    for (int i = 0; i < PUSH_W; i++)
      if (PW'(i) < push_cnt) mem[wr_ptr + AW'(i)] <= push_data[i];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_cnt) - CW'(pop);
    end

  assign head = mem[rd_ptr];
  assign free = CW'(DEPTH) - count;
endmodule

// File: rtl/pipe_stage3_collect.sv
// Collects non-sentinel lanes of the similarity stage into a FIFO and streams them out.
module pipe_stage3_collect
  import pipe_pkg::*;
#(
  parameter logic [WIDTH-1:0] N = pipe_pkg::N,
  parameter int PARALLEL = 2,
  parameter int DEPTH    = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [2:0]                      stage_i,
  input  logic [PARALLEL-1:0][WIDTH-1:0]  center_i,
  input  logic [PARALLEL-1:0][WIDTH-1:0]  dnorm_i,
  pipe_stage3_collect_if.master           out,
  output logic [15:0]                     match_cnt_o,
  output logic [15:0]                     drop_cnt_o,
  output logic                            overflow_o,
  output logic                            done_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(PARALLEL + 1);

  col_state_e                   state;
  logic [CW-1:0]                fifo_cnt, fifo_free, room, acc;
  logic [PW-1:0]                push_cnt, ndrop;
  assign_entry_t [PARALLEL-1:0] lane, push_data;
  assign_entry_t                head;
  logic [PARALLEL-1:0]          cand;
  logic                         collect_en, clr, pop;

  // The IDLE->COLLECT cycle already carries valid stage-6 lanes.
  assign collect_en = (state == IDLE || state == COLLECT) && stage_i == STAGE_SIM;
  assign clr        = state == IDLE && stage_i == STAGE_SIM;
  assign pop        = out.valid & out.ready;

  for (genvar k = 0; k < PARALLEL; k++) begin : g_lane
    assign lane[k] = '{center: center_i[k], dnorm: dnorm_i[k]};
    assign cand[k] = collect_en && center_i[k] != N;
  end

  // Compact candidates in lane order into the first free slots; the rest drop.
  always_comb begin
    acc       = '0;
    ndrop     = '0;
    push_data = '0;
    room      = fifo_free + CW'(pop);
    for (int k = 0; k < PARALLEL; k++)
      if (cand[k]) begin
        if (acc < room) begin
          for (int j = 0; j < PARALLEL; j++)
            if (CW'(j) == acc) push_data[j] = lane[k];
          acc = acc + CW'(1);
        end else begin
          ndrop = ndrop + PW'(1);
        end
      end
    push_cnt = PW'(acc);
  end

  mpush_fifo #(
    .DEPTH  (DEPTH),
    .PUSH_W (PARALLEL),
    .entry_t(assign_entry_t)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push_cnt (push_cnt),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (fifo_cnt),
    .free     (fifo_free)
  );

  assign out.valid  = fifo_cnt != '0;
  assign out.center = head.center;
  assign out.dnorm  = head.dnorm;
  assign out.last   = out.valid && state == DRAIN && fifo_cnt == CW'(1);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      match_cnt_o <= '0;
      drop_cnt_o  <= '0;
      overflow_o  <= 1'b0;
    end else begin
      match_cnt_o <= sat_add16(clr ? 16'h0 : match_cnt_o, 16'(push_cnt));
      drop_cnt_o  <= sat_add16(clr ? 16'h0 : drop_cnt_o, 16'(ndrop));
      overflow_o  <= (clr ? 1'b0 : overflow_o) | (ndrop != '0);
    end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state  <= IDLE;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (stage_i == STAGE_SIM) state <= COLLECT;
          else if (stage_i == STAGE_FIN && fifo_cnt == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        COLLECT:
          if (stage_i == STAGE_FIN) state <= DRAIN;
        DRAIN:
          if (fifo_cnt == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        DONE:
          if (stage_i == STAGE_RST) begin
            state  <= IDLE;
            done_o <= 1'b0;
          end
        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
      endcase
    end
endmodule
